// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and fetches one IMEM word per instruction over a req/rvalid handshake.
// It holds the word for the decoder until the datapath acks it, then steps the PC using NPCOp.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      inst,
  output logic             inst_valid,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4,
  input  logic             inst_ack,
  input  logic [3:0]       NPCOp,
  input  logic [31:0]      rs_data,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} state_t;

  localparam logic [3:0] NPC_PLUS4  = 4'd0;
  localparam logic [3:0] NPC_BRANCH = 4'd1;
  localparam logic [3:0] NPC_JUMP   = 4'd2;
  localparam logic [3:0] NPC_JR     = 4'd3;
  localparam logic [3:0] NPC_JALR   = 4'd4;

  state_t      state, state_nxt;
  logic        load_inst, retire;
  logic [31:0] next_pc, br_off;
  logic        npc_err;

  // The address is simply the PC, which only moves on retire, so it stays stable from req to rvalid.
  assign imem_addr = pc_out;
  assign br_off    = {{14{inst[15]}}, inst[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    npc_err = 1'b0;
    case (NPCOp)
      NPC_PLUS4:  next_pc = pc_plus4;
      NPC_BRANCH: next_pc = pc_plus4 + br_off;
      NPC_JUMP:   next_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
      NPC_JR, NPC_JALR: begin
        next_pc = {rs_data[31:2], 2'b00};
        npc_err = |rs_data[1:0];
      end
      default: begin
        next_pc = pc_plus4;
        npc_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    load_inst = 1'b0;
    retire    = 1'b0;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: if (imem_rvalid) begin
        load_inst = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD: if (inst_ack) begin
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inst       <= '0;
      inst_valid <= 1'b0;
      pc_out     <= RESET_PC;
      pc_plus4   <= RESET_PC + 32'd4;
      fetch_err  <= 1'b0;
      retire_cnt <= '0;
    end else begin
      if (load_inst) begin
        inst       <= imem_rdata;
        inst_valid <= 1'b1;
      end
      if (retire) begin
        pc_out     <= next_pc;
        pc_plus4   <= next_pc + 32'd4;
        inst_valid <= 1'b0;
        retire_cnt <= retire_cnt + CNT_W'(1);
        if (npc_err) fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: each ack pushes the expected next fetch address and each IMEM request pops it.
module tb_if_fetch_unit;
  localparam int          CNT_W = 4;
  localparam logic [31:0] RPC   = 32'h0000_3000;

  logic             clk = 1'b0;
  logic             rstn;
  logic             imem_req, imem_rvalid;
  logic [31:0]      imem_addr, imem_rdata, inst, pc_out, pc_plus4, rs_data;
  logic             inst_valid, inst_ack, fetch_err;
  logic [3:0]       NPCOp;
  logic [CNT_W-1:0] retire_cnt;

  if_fetch_unit #(.RESET_PC(RPC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .inst_ack(inst_ack), .NPCOp(NPCOp), .rs_data(rs_data),
    .fetch_err(fetch_err), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int               n_chk = 0;
  int               n_err = 0;
  logic [31:0]      exp_q[$];
  logic [31:0]      m_pc;
  logic             m_err;
  logic [CNT_W-1:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"},   32'(imem_req),   32'd0);
    chk({tag, "_addr"},  imem_addr,       RPC);
    chk({tag, "_inst"},  inst,            32'd0);
    chk({tag, "_vld"},   32'(inst_valid), 32'd0);
    chk({tag, "_pc"},    pc_out,          RPC);
    chk({tag, "_pc4"},   pc_plus4,        RPC + 32'd4);
    chk({tag, "_err"},   32'(fetch_err),  32'd0);
    chk({tag, "_cnt"},   32'(retire_cnt), 32'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(RPC);
    m_pc  = RPC;
    m_err = 1'b0;
    m_cnt = '0;
  endtask

  // Waits (bounded) for a request and checks its address against the scoreboard.
  task automatic wait_req(output logic ok);
    int t;
    logic [31:0] e;
    t = 0;
    while (imem_req !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = (imem_req === 1'b1);
    if (!ok) begin
      chk("req_timeout", 32'(imem_req), 32'd1);
      return;
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk("fetch_addr", imem_addr, e);
  endtask

  task automatic fetch_one(input int lat, input logic [31:0] data, input int hold,
                           input logic [3:0] op, input logic [31:0] rs, input logic stray);
    logic        ok, err;
    logic [31:0] p4, nxt;
    wait_req(ok);
    if (!ok) return;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      chk("wait_noreq", 32'(imem_req),   32'd0);
      chk("wait_nvld",  32'(inst_valid), 32'd0);
      inst_ack = stray;
      NPCOp    = stray ? 4'hF : 4'h0;
      if (i == lat) begin
        imem_rvalid = 1'b1;
        imem_rdata  = data;
      end
    end
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    inst_ack    = 1'b0;
    NPCOp       = op;
    rs_data     = rs;
    chk("hold_vld",  32'(inst_valid), 32'd1);
    chk("hold_inst", inst,            data);
    chk("hold_pc",   pc_out,          m_pc);
    chk("hold_pc4",  pc_plus4,        m_pc + 32'd4);
    chk("hold_err",  32'(fetch_err),  32'(m_err));
    chk("hold_cnt",  32'(retire_cnt), 32'(m_cnt));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("stall_inst",  inst,            data);
      chk("stall_pc",    pc_out,          m_pc);
      chk("stall_vld",   32'(inst_valid), 32'd1);
      chk("stall_noreq", 32'(imem_req),   32'd0);
    end
    p4  = m_pc + 32'd4;
    err = 1'b0;
    case (op)
      4'd0: nxt = p4;
      4'd1: nxt = p4 + {{14{data[15]}}, data[15:0], 2'b00};
      4'd2: nxt = {p4[31:28], data[25:0], 2'b00};
      4'd3, 4'd4: begin
        nxt = {rs[31:2], 2'b00};
        err = (rs[1:0] != 2'b00);
      end
      default: begin
        nxt = p4;
        err = 1'b1;
      end
    endcase
    exp_q.push_back(nxt);
    inst_ack = 1'b1;
    @(negedge clk);
    inst_ack = 1'b0;
    m_pc  = nxt;
    m_cnt = m_cnt + 1'b1;
    m_err = m_err | err;
    chk("ack_nvld", 32'(inst_valid), 32'd0);
    chk("ack_pc",   pc_out,          m_pc);
    chk("ack_pc4",  pc_plus4,        m_pc + 32'd4);
    chk("ack_err",  32'(fetch_err),  32'(m_err));
    chk("ack_cnt",  32'(retire_cnt), 32'(m_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=%0t exp=done", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ok;
    rstn        = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    inst_ack    = 1'b0;
    NPCOp       = '0;
    rs_data     = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("rst");

    rstn = 1'b1;
    chk("idle_noreq", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("first_req", 32'(imem_req), 32'd1);

    // sequential PLUS4, latency 1
    repeat (3) fetch_one(1, 32'h0000_0000, 0, 4'd0, 32'd0, 1'b0);
    // slow IMEM, stalled ack, stray acks while waiting
    fetch_one(4, 32'h1234_5678, 5, 4'd0, 32'd0, 1'b1);
    // branches at 0x3010
    fetch_one(1, 32'h1000_FFFF, 0, 4'd1, 32'd0, 1'b0);
    fetch_one(1, 32'h1000_0003, 0, 4'd1, 32'd0, 1'b0);
    // JR to 0xA000_0000, then JUMP keeps the top nibble
    fetch_one(1, 32'h0000_0000, 0, 4'd3, 32'hA000_0000, 1'b0);
    fetch_one(2, 32'h0800_0100, 0, 4'd2, 32'd0, 1'b0);
    // misaligned JR, then aligned JALR with sticky error
    fetch_one(1, 32'h0000_0000, 1, 4'd3, 32'h0000_3007, 1'b0);
    fetch_one(1, 32'h0000_0000, 0, 4'd4, 32'h0000_4000, 1'b0);

    // async reset while waiting on IMEM; a simultaneous rvalid must lose
    wait_req(ok);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_reset_vals("arst");
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rst_wins_vld",  32'(inst_valid), 32'd0);
    chk("rst_wins_inst", inst,            32'd0);
    imem_rvalid = 1'b0;
    model_reset();
    rstn = 1'b1;

    // illegal NPCOp, then 15 more acks to wrap the 4-bit counter
    fetch_one(1, 32'h0000_0000, 0, 4'hF, 32'd0, 1'b0);
    for (int i = 0; i < 15; i++) fetch_one(1, $urandom, 0, 4'd0, 32'd0, 1'b0);
    chk("cnt_wrap", 32'(retire_cnt), 32'd0);
    chk("err_sticky", 32'(fetch_err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
